openram_scan_driver: RTL and testbench
======================================

# openram_scan_driver

Host-side initiator for the OpenRAM test chip's GPIO scan interface. It takes one parallel command word, serially scans it into the test chip's instruction register, opens a timed SRAM access window, pulses the SRAM-result capture, and scans the captured register back out. It sits beside the test chip on the same `clk` (FPGA bring-up harness or management-side wrapper) and replaces bit-banged GPIO sequencing.

## Interface
Parameters:
- `TOTAL_SIZE`, 112: scan register length (SELECT 4 + 2 × PORT 54).
- `SRAM_WAIT`, 2: cycles the access window stays open. Legal range is 1 to 255.

Ports:
- `clk` input, 1 bit: single clock shared with the test chip.
- `reset` input, 1 bit: synchronous, active-high. It resets this block only, not the test chip.
- `cmd_valid` input, 1 bit: command word present.
- `cmd_ready` output, 1 bit: block can accept a command. It is 1 only in IDLE.
- `cmd_data` input, `TOTAL_SIZE` bits: word to scan in. Bit `TOTAL_SIZE-1` is the chip-select MSB.
- `cmd_readback` input, 1 bit: when 1, capture and return SRAM results. When 0, the block scans in and runs the window only.
- `rsp_valid` output, 1 bit: response word valid.
- `rsp_ready` input, 1 bit: consumer accepts the response.
- `rsp_data` output, `TOTAL_SIZE` bits: register contents scanned back out.
- `gpio_in` output, 1 bit: serial data to the test chip.
- `gpio_scan` output, 1 bit: shift enable to the test chip.
- `gpio_sram_load` output, 1 bit: one-cycle capture strobe for SRAM read data.
- `gpio_out` input, 1 bit: test chip register MSB. It is combinational from the chip's register.
- `global_csr` output, 1 bit: global chip-select disable. 1 means all SRAMs are deselected.
- `busy` output, 1 bit: the state is anything other than IDLE.

## Operation
- The state machine has six states: IDLE, SHIFT_IN, WAIT, LOAD, SHIFT_OUT, RESP. All outputs are registered or decoded from state.
- Reset values: the state is IDLE and `cmd_ready`=1. The following are all 0: `busy`, `gpio_scan`, `gpio_in`, `gpio_sram_load`, `rsp_valid`, `rsp_data`. `global_csr`=1.
- **IDLE**
  - On `cmd_valid && cmd_ready`, the block loads `cmd_data` into the shift register `sh` and latches `cmd_readback`.
  - It clears the bit counter and moves to SHIFT_IN.
- **SHIFT_IN**
  - Outputs: `gpio_scan`=1 and `gpio_in`=`sh[TOTAL_SIZE-1]`. Each edge shifts `sh` left by one.
  - Bits go out MSB first, so after `TOTAL_SIZE` edges the chip register equals `cmd_data`.
  - After the `TOTAL_SIZE`th edge, go to WAIT.
- **WAIT**
  - Outputs: `gpio_scan`=0 and `global_csr`=0. WAIT is the only state that drives `global_csr` low, which suppresses spurious SRAM accesses while intermediate scan values pass through the chip's CSB field.
  - The state lasts `SRAM_WAIT` cycles.
  - It then goes to LOAD if readback was latched, otherwise to IDLE.
- **LOAD**
  - Outputs: `gpio_sram_load`=1 for exactly one cycle, then go to SHIFT_OUT.
- **SHIFT_OUT**
  - Outputs: `gpio_scan`=1 and `gpio_in`=0.
  - Each edge captures the bit: `rsp_data <= {rsp_data[TOTAL_SIZE-2:0], gpio_out}`.
  - After `TOTAL_SIZE` edges, `rsp_data` equals the chip register as it was after LOAD. Go to RESP.
- **RESP**
  - Outputs: `rsp_valid`=1, with `rsp_data` held stable.
  - On `rsp_ready`, go to IDLE. There is no timeout.
- The bit counter is `$clog2(TOTAL_SIZE+1)` bits wide and saturates to no action outside the shift states.
- The wait counter is 8 bits.

## Timing
- Accept-to-first-scan: `gpio_scan` rises the cycle after the acceptance edge.
- Readback latency: `rsp_valid` rises `2*TOTAL_SIZE + SRAM_WAIT + 1` edges after acceptance. That is 227 for the defaults.
- No-readback: `cmd_ready` returns `TOTAL_SIZE + SRAM_WAIT` edges after acceptance. That is 114 for the defaults.
- `cmd_valid` while busy is ignored, and `cmd_data` is not resampled.
- `rsp_ready` outside RESP is ignored.
- If `rsp_valid && rsp_ready`, then `cmd_ready` is 1 on the following cycle. A new command cannot be accepted in the same cycle as the response handshake.
- Reset mid-operation:
  - On the next edge: the state is IDLE, `gpio_scan` and `gpio_sram_load` are 0, `global_csr` is 1, and any pending response is dropped.
  - The test chip register is left partially shifted. The host must rescan.
- `gpio_out` is sampled on the same edge that shifts the chip register. No extra pipeline stage is allowed.

## Test plan
- **Scan-in pattern:** reset, then send `cmd_data`=0xA5…A5 (112 bits) with readback=0.
  - Expect a 112-cycle `gpio_scan` burst whose `gpio_in` sequence reads 1,0,1,0,0,1,0,1,….
  - The chip register must equal `cmd_data`, and `cmd_ready` must return at edge 114.
- **Readback:** use a behavioural test chip. Set select=3 and sram3_data0=0xDEADBEEF.
  - `rsp_valid` must rise at edge 227.
  - `rsp_data[read_data0 field]` must equal 0xDEADBEEF, and the select and address fields must be unchanged.
- **CSR window:** across one full command, `global_csr`=0 for exactly 2 cycles, both between the last SHIFT_IN and LOAD. `gpio_sram_load` pulses once.
- **Backpressure:**
  - Hold `rsp_ready`=0 for 50 cycles. `rsp_valid` and `rsp_data` must stay stable and `cmd_ready` must stay 0.
  - Assert `cmd_valid` during that time. It must not be accepted.
- **Reset mid-SHIFT_OUT:** assert `reset` at bit 40.
  - Next cycle: all outputs are at reset values and `rsp_valid` never rises.
  - A following command must complete normally.
- **Back-to-back:** send two readback commands with `cmd_valid` held high and `rsp_ready`=1.
  - The second acceptance must occur exactly 2 edges after the first response handshake.

Source files
------------

// File: rtl/openram_scan_driver.sv
// Scan initiator for the OpenRAM test chip: serially loads a command word, opens a timed SRAM window,
// optionally captures and scans results back. Readback latency 2*TOTAL_SIZE+SRAM_WAIT+1; RESP holds until rsp_ready.
module openram_scan_driver #(
  parameter int TOTAL_SIZE = 112,
  parameter int SRAM_WAIT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [TOTAL_SIZE-1:0] cmd_data,
  input  logic                  cmd_readback,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TOTAL_SIZE-1:0] rsp_data,
  output logic                  gpio_in,
  output logic                  gpio_scan,
  output logic                  gpio_sram_load,
  input  logic                  gpio_out,
  output logic                  global_csr,
  output logic                  busy
);

  localparam int CW = $clog2(TOTAL_SIZE + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(TOTAL_SIZE - 1);
  localparam logic [7:0]    LAST_WAIT = 8'(SRAM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_WAIT,
    S_LOAD,
    S_SHIFT_OUT,
    S_RESP
  } state_t;

  state_t                state, state_nxt;
  logic [TOTAL_SIZE-1:0] sh;
  logic [CW-1:0]         bit_cnt;
  logic [7:0]            wait_cnt;
  logic                  readback_q;
  logic                  bit_last;
  logic                  wait_last;

  assign bit_last  = (bit_cnt == LAST_BIT);
  assign wait_last = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Every gpio_* strobe is a pure state decode so the chip sees clean levels.
  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    gpio_scan      = 1'b0;
    gpio_in        = 1'b0;
    gpio_sram_load = 1'b0;
    global_csr     = 1'b1;
    rsp_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_SHIFT_IN;
      end
      S_SHIFT_IN: begin
        gpio_scan = 1'b1;
        gpio_in   = sh[TOTAL_SIZE-1];
        if (bit_last) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Only here may the chip's CSB field reach the SRAMs.
        global_csr = 1'b0;
        if (wait_last) state_nxt = readback_q ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        gpio_sram_load = 1'b1;
        state_nxt      = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        gpio_scan = 1'b1;
        if (bit_last) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh         <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      readback_q <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sh         <= cmd_data;
            readback_q <= cmd_readback;
            bit_cnt    <= '0;
          end
        end
        S_SHIFT_IN: begin
          sh       <= {sh[TOTAL_SIZE-2:0], 1'b0};
          bit_cnt  <= bit_last ? '0 : bit_cnt + CW'(1);
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 8'd1;
        S_SHIFT_OUT: begin
          // gpio_out is the chip MSB before this same edge shifts it.
          rsp_data <= {rsp_data[TOTAL_SIZE-2:0], gpio_out};
          bit_cnt  <= bit_last ? '0 : bit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_openram_scan_driver.sv
// Directed bench for openram_scan_driver with a behavioural test-chip scan register.
module tb_openram_scan_driver;

  localparam int N = 112;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_data;
  logic         cmd_readback;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         gpio_in;
  logic         gpio_scan;
  logic         gpio_sram_load;
  logic         gpio_out;
  logic         global_csr;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  openram_scan_driver #(.TOTAL_SIZE(N), .SRAM_WAIT(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_readback(cmd_readback),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .gpio_in(gpio_in), .gpio_scan(gpio_scan), .gpio_sram_load(gpio_sram_load), .gpio_out(gpio_out),
    .global_csr(global_csr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Test chip: SELECT[111:108], port0[107:54] = {csb,web,wmask[3:0],addr[15:0],data[31:0]}, port1[53:0].
  logic [N-1:0] chip_reg = '0;
  logic [31:0]  sram3_data0 = 32'hDEADBEEF;
  assign gpio_out = chip_reg[N-1];
  always @(posedge clk) begin
    if (gpio_scan) chip_reg <= {chip_reg[N-2:0], gpio_in};
    else if (gpio_sram_load && chip_reg[111:108] == 4'd3) chip_reg[85:54] <= sram3_data0;
  end

  int csr_low_n = 0, load_n = 0, csr_last = 0, load_last = 0;
  always @(negedge clk) begin
    if (!global_csr) begin csr_low_n++; csr_last = cyc; end
    if (gpio_sram_load) begin load_n++; load_last = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] mk(input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0,
                                      input logic [15:0] a1, input logic [31:0] d1);
    return {sel, 1'b0, 1'b1, 4'h0, a0, d0, 1'b1, 1'b1, 4'h0, a1, d1};
  endfunction

  task automatic send(input logic [N-1:0] d, input logic rb, output int acc);
    for (int n = 0; n < 400 && !cmd_ready; n++) tick();
    cmd_data = d; cmd_readback = rb; cmd_valid = 1'b1;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
    chk("accept_busy", N'(busy), N'(1));
  endtask

  task automatic wait_rsp(output int r);
    for (int n = 0; n < 400 && !rsp_valid; n++) tick();
    r = cyc;
    chk("rsp_valid_timeout", N'(rsp_valid), N'(1));
  endtask

  initial begin
    logic [N-1:0] cmd_a5, cmd_rb, exp_rb, cmd_b, seq, snap;
    int a, r, rdy, c0, l0, scan_n, bad_v, bad_d, bad_r, bad_s, seen;

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_readback = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", N'(cmd_ready), N'(1));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_gpio", N'({gpio_scan, gpio_in, gpio_sram_load}), N'(0));
    chk("rst_global_csr", N'(global_csr), N'(1));
    chk("rst_rsp", N'({rsp_valid, rsp_data}), N'(0));
    reset = 1'b0;
    tick();

    // Scan-in of the A5 pattern without readback.
    cmd_a5 = {14{8'hA5}};
    c0 = csr_low_n; l0 = load_n; seq = '0; scan_n = 0;
    send(cmd_a5, 1'b0, a);
    for (int i = 0; i < N; i++) begin
      seq = {seq[N-2:0], gpio_in};
      if (gpio_scan) scan_n++;
      tick();
    end
    chk("scan_in_count", N'(scan_n), N'(112));
    chk("scan_in_sequence", seq, cmd_a5);
    chk("scan_in_end_scan", N'(gpio_scan), N'(0));
    chk("wait_csr_low", N'(global_csr), N'(0));
    for (int n = 0; n < 50 && !cmd_ready; n++) tick();
    rdy = cyc;
    chk("noreadback_ready_edge", N'(rdy - a), N'(114));
    chk("chip_reg_a5", chip_reg, cmd_a5);
    chk("noreadback_csr_cycles", N'(csr_low_n - c0), N'(2));
    chk("noreadback_no_load", N'(load_n - l0), N'(0));
    chk("noreadback_no_rsp", N'(rsp_valid), N'(0));

    // Readback through select 3, with the response held off for 50 cycles.
    cmd_rb = mk(4'd3, 16'h1234, 32'h0000_0000, 16'h0055, 32'h0F0F_0F0F);
    exp_rb = cmd_rb;
    exp_rb[85:54] = 32'hDEADBEEF;
    c0 = csr_low_n; l0 = load_n;
    send(cmd_rb, 1'b1, a);
    wait_rsp(r);
    chk("readback_latency", N'(r - a), N'(227));
    chk("readback_data", rsp_data, exp_rb);
    chk("csr_window_cycles", N'(csr_low_n - c0), N'(2));
    chk("csr_window_last", N'(csr_last - a), N'(113));
    chk("load_pulse_count", N'(load_n - l0), N'(1));
    chk("load_pulse_cycle", N'(load_last - a), N'(114));

    snap = rsp_data; bad_v = 0; bad_d = 0; bad_r = 0; bad_s = 0;
    cmd_data = ~cmd_rb; cmd_readback = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid !== 1'b1) bad_v++;
      if (rsp_data !== snap) bad_d++;
      if (cmd_ready !== 1'b0) bad_r++;
      if (gpio_scan !== 1'b0) bad_s++;
    end
    cmd_valid = 1'b0;
    chk("bp_rsp_valid_held", N'(bad_v), N'(0));
    chk("bp_rsp_data_stable", N'(bad_d), N'(0));
    chk("bp_cmd_ready_low", N'(bad_r), N'(0));
    chk("bp_cmd_not_accepted", N'(bad_s), N'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("handshake_rsp_drop", N'(rsp_valid), N'(0));
    chk("handshake_cmd_ready", N'(cmd_ready), N'(1));

    // Reset while shifting out bit 40.
    send(cmd_rb, 1'b1, a);
    while (cyc < a + 115 + 40) tick();
    chk("mid_shift_out_scan", N'(gpio_scan), N'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_cmd_ready", N'(cmd_ready), N'(1));
    chk("midrst_busy", N'(busy), N'(0));
    chk("midrst_gpio", N'({gpio_scan, gpio_in, gpio_sram_load}), N'(0));
    chk("midrst_global_csr", N'(global_csr), N'(1));
    chk("midrst_rsp", N'({rsp_valid, rsp_data}), N'(0));
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", N'(seen), N'(0));
    send(cmd_rb, 1'b1, a);
    wait_rsp(r);
    chk("after_rst_latency", N'(r - a), N'(227));
    chk("after_rst_data", rsp_data, exp_rb);
    rsp_ready = 1'b1;
    tick();

    // Back-to-back readbacks with cmd_valid held and rsp_ready high.
    cmd_b = mk(4'd2, 16'h00AB, 32'h1111_1111, 16'h7F00, 32'h2222_2222);
    for (int n = 0; n < 10 && !cmd_ready; n++) tick();
    cmd_data = cmd_rb; cmd_readback = 1'b1; cmd_valid = 1'b1;
    tick();
    a = cyc;
    cmd_data = cmd_b;
    wait_rsp(r);
    chk("b2b_first_latency", N'(r - a), N'(227));
    chk("b2b_first_data", rsp_data, exp_rb);
    for (int n = 0; n < 5 && busy; n++) tick();
    for (int n = 0; n < 5 && !busy; n++) tick();
    chk("b2b_second_accept", N'(cyc - r), N'(2));
    cmd_valid = 1'b0;
    wait_rsp(r);
    chk("b2b_second_data", rsp_data, cmd_b);
    tick();
    chk("b2b_final_ready", N'(cmd_ready), N'(1));
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
